// File: rtl/cu_pkg.sv
// cu_pkg: shared opcodes, ALU codes, FSM states and instruction classes for the multicycle control unit
// Ports: none (package only).
package cu_pkg;
   localparam int OP_RTYPE = 0;
   localparam int OP_ADDI  = 1;
   localparam int OP_ORI   = 2;
   localparam int OP_ANDI  = 3;
   localparam int OP_LW    = 4;
   localparam int OP_SW    = 5;
   localparam int OP_BEQ   = 6;
   localparam int OP_BGT   = 7;
   localparam int OP_JUMP  = 8;
   localparam int ALU_AND   = 0;
   localparam int ALU_OR    = 1;
   localparam int ALU_ADD   = 2;
   localparam int ALU_SUB   = 3;
   localparam int ALU_FUNCT = 4;
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;
   // C_ALU covers R-type and all register-immediate ops: they share the EXEC->WB path
   typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_BGT, C_JUMP} cls_t;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode decode into static datapath selects, ALU op, class and illegal flag
// Ports: opcode in; reg_dst, alu_src, mem_to_reg, ext_op, alu_op, cls, illegal out.
module cu_decode
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 3
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic                reg_dst,
   output logic                alu_src,
   output logic                mem_to_reg,
   output logic                ext_op,
   output logic [ALUOP_W-1:0]  alu_op,
   output cls_t                cls,
   output logic                illegal
);
   always_comb begin
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      ext_op     = 1'b0;
      alu_op     = '0;
      cls        = C_ALU;
      illegal    = 1'b0;
      case (32'(opcode))
         OP_RTYPE: begin reg_dst = 1'b1; alu_op = ALUOP_W'(ALU_FUNCT); end
         OP_ADDI:  begin alu_src = 1'b1; alu_op = ALUOP_W'(ALU_ADD); end
         OP_ORI:   begin alu_src = 1'b1; alu_op = ALUOP_W'(ALU_OR); end
         OP_ANDI:  begin alu_src = 1'b1; alu_op = ALUOP_W'(ALU_AND); end
         OP_LW:    begin alu_src = 1'b1; mem_to_reg = 1'b1; ext_op = 1'b1; alu_op = ALUOP_W'(ALU_ADD); cls = C_LW; end
         OP_SW:    begin alu_src = 1'b1; ext_op = 1'b1; alu_op = ALUOP_W'(ALU_ADD); cls = C_SW; end
         OP_BEQ:   begin ext_op = 1'b1; alu_op = ALUOP_W'(ALU_SUB); cls = C_BEQ; end
         OP_BGT:   begin ext_op = 1'b1; alu_op = ALUOP_W'(ALU_SUB); cls = C_BGT; end
         OP_JUMP:  cls = C_JUMP;
         default:  illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake, timeout and illegal-opcode flag
// Ports: clk, rst_n (synchronous, active low); opcode (sampled in DECODE); mem_ready;
//   strobes pc_write, ir_write, mem_read, mem_write, reg_write; selects reg_dst, alu_src, mem_to_reg, ext_op;
//   branch_eq, branch_gr, jump; alu_op; pulses illegal_op, bus_error, instr_done; state (debug);
//   instr_count, cycle_count: counters when MULTICYCLE_CU_PERF_CNT_EN is defined, tied to 0 otherwise.
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                ir_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                alu_src,
   output logic                mem_to_reg,
   output logic                ext_op,
   output logic                branch_eq,
   output logic                branch_gr,
   output logic                jump,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                illegal_op,
   output logic                bus_error,
   output logic                instr_done,
   output logic [2:0]          state,
   output logic [CNT_W-1:0]    instr_count,
   output logic [CNT_W-1:0]    cycle_count
);
   localparam int TW = $clog2(MEM_TIMEOUT) + 1;
   state_t st, nxt;
   cls_t cls_q, ncls, d_cls;
   logic d_reg_dst, d_alu_src, d_mem_to_reg, d_ext_op, d_illegal;
   logic [ALUOP_W-1:0] d_alu_op;
   logic [TW-1:0] tcnt;
   logic fetch_ok, waiting, timeout, is_branch;
   cu_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_dec (
      .opcode(opcode), .reg_dst(d_reg_dst), .alu_src(d_alu_src), .mem_to_reg(d_mem_to_reg),
      .ext_op(d_ext_op), .alu_op(d_alu_op), .cls(d_cls), .illegal(d_illegal)
   );
   // The first FETCH cycle after reset has no read outstanding, so mem_ready is ignored there
   assign fetch_ok   = st == S_FETCH && mem_read && mem_ready;
   assign waiting    = ((st == S_FETCH && mem_read) || st == S_MEM) && !mem_ready;
   assign timeout    = waiting && tcnt == TW'(MEM_TIMEOUT - 1);
   assign is_branch  = cls_q == C_BEQ || cls_q == C_BGT || cls_q == C_JUMP;
   assign ncls       = st == S_DECODE ? d_cls : cls_q;
   assign pc_write   = fetch_ok;
   assign ir_write   = fetch_ok;
   assign illegal_op = st == S_DECODE && d_illegal;
   assign instr_done = st == S_WB || (st == S_EXEC && is_branch) || (st == S_MEM && mem_ready && cls_q == C_SW);
   assign state      = st;
   always_comb begin
      nxt = S_FETCH;
      case (st)
         S_FETCH:  nxt = fetch_ok ? S_DECODE : S_FETCH;
         S_DECODE: nxt = d_illegal ? S_FETCH : S_EXEC;
         S_EXEC:   nxt = cls_q == C_ALU ? S_WB : (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_FETCH;
         S_MEM:    nxt = mem_ready ? (cls_q == C_LW ? S_WB : S_FETCH) : timeout ? S_FETCH : S_MEM;
         default:  nxt = S_FETCH;
      endcase
   end
   // Strobes are registered from the next state so each is valid for the whole cycle it belongs to
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st         <= S_FETCH;
         cls_q      <= C_ALU;
         tcnt       <= '0;
         bus_error  <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         reg_write  <= 1'b0;
         branch_eq  <= 1'b0;
         branch_gr  <= 1'b0;
         jump       <= 1'b0;
         reg_dst    <= 1'b0;
         alu_src    <= 1'b0;
         mem_to_reg <= 1'b0;
         ext_op     <= 1'b0;
         alu_op     <= '0;
      end else begin
         st         <= nxt;
         cls_q      <= ncls;
         tcnt       <= waiting && !timeout ? tcnt + 1'b1 : '0;
         bus_error  <= timeout;
         mem_read   <= nxt == S_FETCH || (nxt == S_MEM && ncls == C_LW);
         mem_write  <= nxt == S_MEM && ncls == C_SW;
         reg_write  <= nxt == S_WB;
         branch_eq  <= nxt == S_EXEC && ncls == C_BEQ;
         branch_gr  <= nxt == S_EXEC && ncls == C_BGT;
         jump       <= nxt == S_EXEC && ncls == C_JUMP;
         if (nxt == S_FETCH) begin
            reg_dst    <= 1'b0;
            alu_src    <= 1'b0;
            mem_to_reg <= 1'b0;
            ext_op     <= 1'b0;
            alu_op     <= '0;
         end else if (st == S_DECODE) begin
            reg_dst    <= d_reg_dst;
            alu_src    <= d_alu_src;
            mem_to_reg <= d_mem_to_reg;
            ext_op     <= d_ext_op;
            alu_op     <= d_alu_op;
         end
      end
   end
`ifdef MULTICYCLE_CU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_count <= '0;
         cycle_count <= '0;
      end else begin
         instr_count <= instr_count + CNT_W'(instr_done);
         cycle_count <= cycle_count + 1'b1;
      end
   end
`else
   assign instr_count = '0;
   assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction streams checked against a per-instruction cycle trace model
// Ports: none (testbench top).
module tb_multicycle_control_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic mem_ready = 1'b0;
   logic pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src, mem_to_reg, ext_op;
   logic branch_eq, branch_gr, jump, illegal_op, bus_error, instr_done;
   logic [2:0] alu_op, state;
   logic [31:0] instr_count, cycle_count;
   logic [20:0] dv;
   typedef struct packed {
      logic       rdy;
      logic [5:0] op;
      logic [20:0] exp;
   } cyc_t;
   cyc_t q[$];
   int n_tests = 0;
   int n_fail = 0;
   int kcyc = 0;
   int edone = 0;
   bit pend_be = 1'b0;
   // {reg_dst, alu_src, mem_to_reg, ext_op, alu_op[2:0]} for opcodes 0..8
   bit [6:0] sel_tab[9] = '{7'b1000100, 7'b0100010, 7'b0100001, 7'b0100000, 7'b0111010,
                            7'b0101010, 7'b0001011, 7'b0001011, 7'b0000000};
   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .ext_op(ext_op), .branch_eq(branch_eq), .branch_gr(branch_gr), .jump(jump),
      .alu_op(alu_op), .illegal_op(illegal_op), .bus_error(bus_error), .instr_done(instr_done),
      .state(state), .instr_count(instr_count), .cycle_count(cycle_count)
   );
   always #5 clk = ~clk;
   assign dv = {state, pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src, mem_to_reg,
                ext_op, alu_op, branch_eq, branch_gr, jump, illegal_op, bus_error, instr_done};
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, kcyc);
      end
   endtask
   function automatic logic [20:0] vec(int s, bit pcw, bit mr, bit mw, bit rw, bit [6:0] sel,
                                       bit [2:0] pcs, bit ill, bit be, bit done);
      return {3'(s), pcw, pcw, mr, mw, rw, sel, pcs, ill, be, done};
   endfunction
   function automatic logic [5:0] rnd_op();
      return 6'($urandom);
   endfunction
   task automatic push(input bit rdy, input logic [5:0] op, input logic [20:0] e);
      q.push_back({rdy, op, e});
   endtask
   // Expected cycle-by-cycle trace of one instruction: fw ready-low FETCH cycles, mw ready-low MEM cycles
   task automatic gen(input int op, input int fw, input int mw);
      bit ill = op > 8;
      bit [6:0] s = ill ? 7'd0 : sel_tab[ill ? 0 : op];
      bit be = pend_be;
      bit lw = op == 4;
      pend_be = 1'b0;
      for (int i = 0; i < fw; i++) begin
         push(1'b0, rnd_op(), vec(0, 0, 1, 0, 0, 0, 0, 0, be, 0));
         be = 1'b0;
      end
      push(1'b1, rnd_op(), vec(0, 1, 1, 0, 0, 0, 0, 0, be, 0));
      push(1'($urandom), 6'(op), vec(1, 0, 0, 0, 0, 0, 0, ill, 0, 0));
      if (ill) return;
      if (op >= 6) begin
         push(1'($urandom), rnd_op(), vec(2, 0, 0, 0, 0, s, op == 6 ? 3'b100 : op == 7 ? 3'b010 : 3'b001, 0, 0, 1));
         return;
      end
      push(1'($urandom), rnd_op(), vec(2, 0, 0, 0, 0, s, 0, 0, 0, 0));
      if (op < 4) begin
         push(1'($urandom), rnd_op(), vec(4, 0, 0, 0, 1, s, 0, 0, 0, 1));
         return;
      end
      for (int i = 0; i < mw && i < 16; i++) push(1'b0, rnd_op(), vec(3, 0, lw, !lw, 0, s, 0, 0, 0, 0));
      if (mw >= 16) begin
         pend_be = 1'b1;
         return;
      end
      push(1'b1, rnd_op(), vec(3, 0, lw, !lw, 0, s, 0, 0, 0, !lw));
      if (lw) push(1'($urandom), rnd_op(), vec(4, 0, 0, 0, 1, s, 0, 0, 0, 1));
   endtask
   task automatic play(input string tag, input int n);
      cyc_t c;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         c = q.pop_front();
         @(negedge clk);
         kcyc++;
         mem_ready = c.rdy;
         opcode = c.op;
         #1;
         chk(tag, 64'(dv), 64'(c.exp));
`ifdef MULTICYCLE_CU_PERF_CNT_EN
         chk("cycle_count", 64'(cycle_count), 64'(kcyc));
         chk("instr_count", 64'(instr_count), 64'(edone));
`endif
         if (c.exp[0]) edone++;
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", 64'(dv), 64'd0);
      chk("reset_cycle_count", 64'(cycle_count), 64'd0);
      chk("reset_instr_count", 64'(instr_count), 64'd0);
      rst_n = 1'b1;
      gen(0, 0, 0);  play("rtype", 100);
      gen(4, 0, 3);  play("lw_wait3", 100);
      gen(6, 0, 0);  play("beq", 100);
      gen(63, 0, 0); play("illegal63", 100);
      gen(5, 0, 16); play("sw_timeout", 100);
      gen(8, 2, 0);  play("jump_after_timeout", 100);
      gen(7, 15, 0); play("bgt_fetch15", 100);
      gen(4, 0, 15); play("lw_wait15", 100);
      for (int i = 0; i < 150; i++) begin
         int op, fw, mw;
         op = ($urandom % 10 == 0) ? int'($urandom_range(9, 63)) : int'($urandom_range(0, 8));
         fw = ($urandom % 16 == 0) ? 15 : int'($urandom_range(0, 3));
         mw = ($urandom % 8 == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
         gen(op, fw, mw);
         play("random", 100);
      end
      gen(5, 1, 10);
      play("sw_pre_reset", 7);
      q.delete();
      pend_be = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("midmem_reset_state", 64'(state), 64'd0);
      chk("midmem_reset_mem_write", 64'(mem_write), 64'd0);
      chk("midmem_reset_outputs", 64'(dv), 64'd0);
      chk("midmem_reset_cycle_count", 64'(cycle_count), 64'd0);
      chk("midmem_reset_instr_count", 64'(instr_count), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
